// File: rtl/calc_frame_capture.sv
// rtl/calc_frame_capture.sv - serial key-stream to parallel calculator command capture
module calc_frame_capture #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Active,
    input  logic                  Mode,
    input  logic                  ValidCmd,
    input  logic                  InputKey,
    output logic                  Busy,
    output logic [OP_WIDTH-1:0]   Sel,
    output logic [DATA_WIDTH-1:0] InA,
    output logic [DATA_WIDTH-1:0] InB,
    output logic                  Unary,
    output logic                  CmdValid,
    output logic                  Abort
);

    // Frame lengths in bits for binary (Sel,A,B) and unary (Sel,A) commands.
    localparam int LEN_BIN = OP_WIDTH + 2 * DATA_WIDTH;
    localparam int LEN_UN  = OP_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(LEN_BIN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                 state;
    logic                   frame_mode;
    // Holds all but the final bit; the final bit is taken directly from InputKey.
    logic [LEN_BIN-2:0]     shift_q;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       last_idx;
    logic [LEN_BIN-1:0]     frame_word;
    logic [OP_WIDTH-1:0]    cap_sel;
    logic [DATA_WIDTH-1:0]  cap_a;
    logic [DATA_WIDTH-1:0]  cap_b;

    assign last_idx   = frame_mode ? CNT_W'(LEN_UN - 1) : CNT_W'(LEN_BIN - 1);
    assign frame_word = {shift_q, InputKey};

    // Split the completed frame into fields; a unary frame occupies the low LEN_UN bits.
    always_comb begin
        cap_sel = '0;
        cap_a   = '0;
        cap_b   = '0;
        if (frame_mode) begin
            cap_sel = frame_word[LEN_UN-1 -: OP_WIDTH];
            cap_a   = frame_word[DATA_WIDTH-1:0];
        end else begin
            cap_sel = frame_word[LEN_BIN-1 -: OP_WIDTH];
            cap_a   = frame_word[2*DATA_WIDTH-1 -: DATA_WIDTH];
            cap_b   = frame_word[DATA_WIDTH-1:0];
        end
    end

    // Frame FSM with registered status strobes and captured command outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            frame_mode <= 1'b0;
            shift_q    <= '0;
            bit_cnt    <= '0;
            Busy       <= 1'b0;
            Sel        <= '0;
            InA        <= '0;
            InB        <= '0;
            Unary      <= 1'b0;
            CmdValid   <= 1'b0;
            Abort      <= 1'b0;
        end else begin
            CmdValid <= 1'b0;
            Abort    <= 1'b0;
            case (state)
                IDLE: begin
                    Busy <= 1'b0;
                    if (Active) begin
                        frame_mode <= Mode;
                        bit_cnt    <= '0;
                        shift_q    <= '0;
                        Busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Losing Active wins over a simultaneous final bit.
                    if (!Active) begin
                        state   <= IDLE;
                        Busy    <= 1'b0;
                        Abort   <= 1'b1;
                        bit_cnt <= '0;
                    end else if (ValidCmd) begin
                        if (bit_cnt == last_idx) begin
                            Sel      <= cap_sel;
                            InA      <= cap_a;
                            InB      <= cap_b;
                            Unary    <= frame_mode;
                            CmdValid <= 1'b1;
                            Busy     <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= WAIT;
                        end else begin
                            shift_q <= {shift_q[LEN_BIN-3:0], InputKey};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    // Key stream is ignored until the decoder drops Active.
                    Busy <= 1'b0;
                    if (!Active) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_frame_capture.sv
// tb/tb_calc_frame_capture.sv - self-checking bench for calc_frame_capture
module tb_calc_frame_capture;

    logic       Clk = 1'b0;
    logic       Reset, Active, Mode, ValidCmd, InputKey;
    logic       Busy, Unary, CmdValid, Abort;
    logic [3:0] Sel;
    logic [7:0] InA, InB;

    int errors = 0;
    int checks = 0;

    // Reference model: the command last delivered to the ALU.
    logic [3:0] m_sel;
    logic [7:0] m_a, m_b;
    logic       m_un;

    typedef struct {
        logic       mode;
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        int         stall_after;
        int         stall_len;
        int         drop_at;
        int         wait_cycles;
        logic       exp_cmd;
        logic [3:0] e_sel;
        logic [7:0] e_a;
        logic [7:0] e_b;
        logic       e_un;
    } vec_t;

    vec_t vecs[8];

    calc_frame_capture #(.DATA_WIDTH(8), .OP_WIDTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .Active(Active), .Mode(Mode),
        .ValidCmd(ValidCmd), .InputKey(InputKey), .Busy(Busy),
        .Sel(Sel), .InA(InA), .InB(InB), .Unary(Unary),
        .CmdValid(CmdValid), .Abort(Abort)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] s, input logic [7:0] a,
                              input logic [7:0] b, input logic u);
        check({tag, "_sel"}, 32'(Sel), 32'(s));
        check({tag, "_ina"}, 32'(InA), 32'(a));
        check({tag, "_inb"}, 32'(InB), 32'(b));
        check({tag, "_unary"}, 32'(Unary), 32'(u));
    endtask

    task automatic send_frame(input vec_t v);
        logic [19:0] word;
        int          len;
        int          busy_cnt;
        bit          completed;
        len       = v.mode ? 12 : 20;
        word      = v.mode ? {8'h00, v.sel, v.a} : {v.sel, v.a, v.b};
        completed = 1'b0;
        Active = 1'b1; Mode = v.mode; ValidCmd = 1'b0; InputKey = 1'b0;
        step();
        check("start_busy", 32'(Busy), 32'd1);
        busy_cnt = int'(Busy);
        Mode = ~v.mode;
        for (int i = 0; i < len; i++) begin
            ValidCmd = 1'b1;
            InputKey = word[len-1-i];
            if (i == v.drop_at) Active = 1'b0;
            step();
            if (i == v.drop_at || i == len - 1) begin
                check("end_cmdvalid", 32'(CmdValid), 32'(v.exp_cmd));
                check("end_abort", 32'(Abort), 32'(!v.exp_cmd));
                check("end_busy", 32'(Busy), 32'd0);
                check_outs("end", v.e_sel, v.e_a, v.e_b, v.e_un);
                if (v.exp_cmd) check("busy_cycles", 32'(busy_cnt), 32'(len + v.stall_len));
                completed = (i != v.drop_at);
                break;
            end
            busy_cnt += int'(Busy);
            check("mid_cmdvalid", 32'(CmdValid | Abort), 32'd0);
            if (i == v.stall_after) begin
                for (int k = 0; k < v.stall_len; k++) begin
                    ValidCmd = 1'b0;
                    InputKey = 1'($urandom);
                    step();
                    busy_cnt += int'(Busy);
                    check("stall_cmdvalid", 32'(CmdValid), 32'd0);
                end
            end
        end
        ValidCmd = 1'b0;
        if (completed) begin
            step();
            check("pulse_one_cycle", 32'(CmdValid), 32'd0);
            for (int k = 0; k < v.wait_cycles; k++) begin
                ValidCmd = 1'($urandom);
                InputKey = 1'($urandom);
                step();
                check("wait_busy", 32'(Busy), 32'd0);
                check("wait_cmdvalid", 32'(CmdValid | Abort), 32'd0);
            end
            ValidCmd = 1'b0;
        end
        Active = 1'b0;
        step();
        check("idle_busy", 32'(Busy), 32'd0);
        check("idle_strobes", 32'(CmdValid | Abort), 32'd0);
        check_outs("hold", v.e_sel, v.e_a, v.e_b, v.e_un);
        m_sel = v.e_sel; m_a = v.e_a; m_b = v.e_b; m_un = v.e_un;
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{1'b0, 4'h3, 8'h5A, 8'h0F, -1, 0, -1,  0, 1'b1, 4'h3, 8'h5A, 8'h0F, 1'b0};
        vecs[1] = '{1'b1, 4'hA, 8'hC3, 8'h77,  4, 3, -1,  0, 1'b1, 4'hA, 8'hC3, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 4'h3, 8'h5A, 8'h0F, -1, 0, -1,  0, 1'b1, 4'h3, 8'h5A, 8'h0F, 1'b0};
        vecs[3] = '{1'b0, 4'h9, 8'h11, 8'h22, -1, 0,  9,  0, 1'b0, 4'h3, 8'h5A, 8'h0F, 1'b0};
        vecs[4] = '{1'b0, 4'hF, 8'hFF, 8'hFF,  2, 2, 19,  0, 1'b0, 4'h3, 8'h5A, 8'h0F, 1'b0};
        vecs[5] = '{1'b1, 4'h5, 8'h96, 8'hEE, -1, 0, -1, 10, 1'b1, 4'h5, 8'h96, 8'h00, 1'b1};
        vecs[6] = '{1'b1, 4'h0, 8'hFF, 8'h00, -1, 0, 11,  0, 1'b0, 4'h5, 8'h96, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 4'hF, 8'h80, 8'h01,  0, 1, -1,  0, 1'b1, 4'hF, 8'h80, 8'h01, 1'b0};

        Reset = 1'b1; Active = 1'b0; Mode = 1'b0; ValidCmd = 1'b0; InputKey = 1'b0;
        step();
        step();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_strobes", 32'(CmdValid | Abort), 32'd0);
        check_outs("rst", 4'h0, 8'h00, 8'h00, 1'b0);
        Reset = 1'b0;
        step();

        for (int n = 0; n < 8; n++) send_frame(vecs[n]);

        // Reset in the middle of a frame, then a clean frame from bit 0.
        Active = 1'b1; Mode = 1'b0; ValidCmd = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            ValidCmd = 1'b1; InputKey = 1'($urandom);
            step();
        end
        Reset = 1'b1;
        step();
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_strobes", 32'(CmdValid | Abort), 32'd0);
        check_outs("midrst", 4'h0, 8'h00, 8'h00, 1'b0);
        Reset = 1'b0; Active = 1'b0; ValidCmd = 1'b0;
        step();
        check("midrst_idle", 32'(Busy), 32'd0);
        send_frame('{1'b0, 4'h6, 8'hA5, 8'h3C, -1, 0, -1, 0, 1'b1, 4'h6, 8'hA5, 8'h3C, 1'b0});

        // Random frames against the command model.
        for (int n = 0; n < 40; n++) begin
            rv.mode        = 1'($urandom);
            rv.sel         = 4'($urandom);
            rv.a           = 8'($urandom);
            rv.b           = 8'($urandom);
            rv.stall_after = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1;
            rv.stall_len   = (rv.stall_after >= 0) ? int'($urandom_range(1, 4)) : 0;
            rv.drop_at     = ($urandom_range(0, 3) == 0)
                             ? int'($urandom_range(0, rv.mode ? 11 : 19)) : -1;
            rv.wait_cycles = int'($urandom_range(0, 3));
            rv.exp_cmd     = (rv.drop_at < 0);
            if (rv.exp_cmd) begin
                rv.e_sel = rv.sel;
                rv.e_a   = rv.a;
                rv.e_b   = rv.mode ? 8'h00 : rv.b;
                rv.e_un  = rv.mode;
            end else begin
                rv.e_sel = m_sel;
                rv.e_a   = m_a;
                rv.e_b   = m_b;
                rv.e_un  = m_un;
            end
            send_frame(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_frame_capture.md
Name: calc_frame_capture

Overview:
Serial-to-parallel command capture stage that sits directly downstream of the key-sequence decoder. The decoder asserts Active and Mode once it recognises the start pattern. This block then shifts the serial InputKey stream, qualified by ValidCmd, into an opcode and one or two operands. It presents them as a registered parallel command with a one-cycle CmdValid strobe to the calculator ALU.

Parameters:
DATA_WIDTH, 8, width of each operand InA/InB
OP_WIDTH, 4, width of opcode Sel

Ports:
Clk  input  1  clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Active  input  1  from key decoder; frame capture enabled while high
Mode  input  1  from key decoder; 0 = binary frame (Sel,A,B), 1 = unary frame (Sel,A)
ValidCmd  input  1  qualifies InputKey; a bit is sampled only when high
InputKey  input  1  serial data bit, MSB first
Busy  output  1  high while in SHIFT state
Sel  output  OP_WIDTH  captured opcode
InA  output  DATA_WIDTH  captured operand A
InB  output  DATA_WIDTH  captured operand B (0 for unary frames)
Unary  output  1  copy of Mode latched for the last completed frame
CmdValid  output  1  one-cycle pulse when Sel/InA/InB/Unary update
Abort  output  1  one-cycle pulse when a frame is abandoned

Behaviour:
- Reset values: state IDLE; Busy, CmdValid, Abort, Unary = 0; Sel, InA, InB = 0; shift register and bit counter = 0. Reset has priority over all other activity, including mid-frame.
- Frame length L:
  - Mode=0: OP_WIDTH + 2*DATA_WIDTH (20 at defaults).
  - Mode=1: OP_WIDTH + DATA_WIDTH (12 at defaults).
- Field order on the wire: Sel first, then A, then B (binary frames only). Each field is sent MSB first.
- States: IDLE, SHIFT, WAIT.
- IDLE:
  - Busy=0.
  - If Active=1, latch Mode into the internal frame-mode register, clear the counter, and go to SHIFT.
  - No bit is sampled in the IDLE cycle.
- SHIFT:
  - Busy=1.
  - Each edge with ValidCmd=1 shifts InputKey into the shift register LSB and increments the counter.
  - ValidCmd=0 holds the shift register and counter (stall, no timeout).
  - Completion: on the edge that samples bit L-1, go to WAIT and load the outputs on that same edge:
    - Sel, InA, InB split from the shift register plus the incoming bit.
    - InB = 0 when the latched mode is 1.
    - Unary = latched mode.
  - CmdValid is high for exactly the cycle after the last bit, i.e. a latency of 1 cycle from the last sampled bit.
  - Abort: if Active=0 in SHIFT before completion, go to IDLE and pulse Abort for one cycle.
    - Sel, InA, InB, Unary keep their previous values.
    - The counter is cleared and no CmdValid is issued.
  - Simultaneous events: Active=0 on the same edge as the last valid bit is an abort. Active is checked before completion.
- WAIT:
  - Busy=0.
  - Ignore ValidCmd and InputKey.
  - Return to IDLE when Active=0; no Abort pulse.
  - A new frame needs Active low for at least one cycle and then high again.
- Mode changes after IDLE exit are ignored for the current frame.
- Outputs hold their value until the next completed frame or reset.
- CmdValid and Abort are never high in the same cycle.

Test Plan:
- Binary frame, no stalls:
  - Stimulus: Reset, then Active=1, Mode=0, ValidCmd=1; stream Sel=0011, A=0x5A, B=0x0F (20 bits).
  - Required: Busy high for 20 cycles; CmdValid one cycle after bit 20 with Sel=0x3, InA=0x5A, InB=0x0F, Unary=0.
- Unary frame with stalls:
  - Stimulus: Mode=1; stream Sel=1010, A=0xC3 with ValidCmd low for 3 cycles after bit 5.
  - Required: CmdValid after bit 12 with Sel=0xA, InA=0xC3, InB=0x00, Unary=1; no shift during stalls.
- Abort mid-frame:
  - Stimulus: after binary frame 1 completes, start a new frame and drop Active after 9 bits.
  - Required: Abort pulses once, state IDLE, outputs remain 0x3/0x5A/0x0F, no CmdValid.
- Active drop on last bit:
  - Stimulus: Active=0 on the edge of bit 20.
  - Required: Abort=1, CmdValid=0, outputs unchanged.
- WAIT re-arm:
  - Stimulus: after a completed frame, hold Active=1 and toggle InputKey/ValidCmd for 10 cycles.
  - Required: no Busy and no CmdValid. After Active goes 0 then 1, a new frame is accepted.
- Reset mid-frame:
  - Stimulus: assert Reset after 7 bits.
  - Required: next cycle all outputs 0 and state IDLE; the following frame captures correctly from bit 0.
